lsu_mem_port: RTL and testbench

- Parametrised load/store unit between the hart's memory stage and a realistic, variable-latency data memory.
- Replaces the combinational single-cycle dmem port with a valid/ready request channel and a separate read-response channel.
- Handles XLEN-generic alignment, byte-lane masking, store-data lane placement and load sign/zero extension.
- Flags misaligned, illegal-width and timed-out accesses as traps to the pipeline.

---
 rtl/lsu_mem_port_if.sv | 36 +++
 rtl/lsu_mem_port.sv | 136 +++++++++++++
 tb/tb_lsu_mem_port.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: pipeline request/response channel plus data-memory bus of the load/store unit
//   slave  : unit side   (i_req_* / i_mem_* in, o_req_* / o_rsp_* / o_mem_* out)
//   master : environment side (pipeline + memory), opposite directions
interface lsu_mem_port_if #(parameter int XLEN = 32);
  localparam int MW = XLEN / 8;
  logic            i_req_valid;
  logic            o_req_ready;
  logic            i_req_wen;
  logic [2:0]      i_req_funct3;
  logic [XLEN-1:0] i_req_addr;
  logic [XLEN-1:0] i_req_wdata;
  logic            o_rsp_valid;
  logic [XLEN-1:0] o_rsp_rdata;
  logic            o_rsp_trap;
  logic            o_mem_valid;
  logic            i_mem_ready;
  logic [XLEN-1:0] o_mem_addr;
  logic            o_mem_wen;
  logic            o_mem_ren;
  logic [XLEN-1:0] o_mem_wdata;
  logic [MW-1:0]   o_mem_mask;
  logic            i_mem_rvalid;
  logic [XLEN-1:0] i_mem_rdata;
  modport slave (
    input  i_req_valid, i_req_wen, i_req_funct3, i_req_addr, i_req_wdata,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_trap,
    output o_mem_valid, o_mem_addr, o_mem_wen, o_mem_ren, o_mem_wdata, o_mem_mask
  );
  modport master (
    output i_req_valid, i_req_wen, i_req_funct3, i_req_addr, i_req_wdata,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_trap,
    input  o_mem_valid, o_mem_addr, o_mem_wen, o_mem_ren, o_mem_wdata, o_mem_mask
  );
endinterface

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit bridging the memory stage to a variable-latency data memory
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : request/response channel to the pipeline and valid/ready bus to memory
module lsu_mem_port #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input logic            i_clk,
  input logic            i_rst_n,
  lsu_mem_port_if.slave  bus
);
  localparam int MW = XLEN / 8;
  localparam int OW = $clog2(MW);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [OW-1:0]   off_q, off_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            trap_q, trap_d;
  logic            wen_q, wen_d, ren_q, ren_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [MW-1:0]   mask_q, mask_d;
  logic            ready_q, mvalid_q, rvalid_q;
  logic [1:0]      sz, lsz;
  logic [OW-1:0]   off;
  logic            legal, hit;
  logic [MW-1:0]   bm;
  logic [XLEN-1:0] trunc, sh, ext;
  always_comb begin
    sz    = bus.i_req_funct3[1:0];
    off   = bus.i_req_addr[OW-1:0];
    legal = !(bus.i_req_funct3 == 3'b111 ||
              (XLEN == 32 && (sz == 2'd3 || bus.i_req_funct3 == 3'b110)) ||
              (bus.i_req_wen && bus.i_req_funct3[2]) ||
              (sz == 2'd1 && bus.i_req_addr[0]) ||
              (sz == 2'd2 && bus.i_req_addr[1:0] != 2'd0) ||
              (sz == 2'd3 && bus.i_req_addr[2:0] != 3'd0));
    bm    = sz == 2'd0 ? MW'(1) : sz == 2'd1 ? MW'(3) : sz == 2'd2 ? MW'(15) : '1;
    trunc = sz == 2'd0 ? XLEN'(bus.i_req_wdata[7:0]) :
            sz == 2'd1 ? XLEN'(bus.i_req_wdata[15:0]) :
            sz == 2'd2 ? XLEN'(bus.i_req_wdata[31:0]) : bus.i_req_wdata;
    lsz   = f3_q[1:0];
    sh    = bus.i_mem_rdata >> {off_q, 3'b000};
    ext   = lsz == 2'd0 ? (f3_q[2] ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]))) :
            lsz == 2'd1 ? (f3_q[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]))) :
            lsz == 2'd2 ? (f3_q[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]))) : sh;
    // final WAIT cycle of the budget: counter starts at 0, so TIMEOUT cycles elapse here
    hit   = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
    state_d = state_q;
    f3_d    = f3_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    trap_d  = trap_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: if (bus.i_req_valid) begin
        f3_d    = bus.i_req_funct3;
        off_d   = off;
        addr_d  = bus.i_req_addr & ~XLEN'(MW - 1);
        mask_d  = bm << off;
        wdata_d = trunc << {off, 3'b000};
        wen_d   = legal && bus.i_req_wen;
        ren_d   = legal && !bus.i_req_wen;
        trap_d  = !legal;
        rdata_d = '0;
        state_d = legal ? REQ : RESP;
      end
      REQ: if (bus.i_mem_ready) begin
        state_d = wen_q ? RESP : WAIT;
        cnt_d   = '0;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
      end
      WAIT: begin
        state_d = bus.i_mem_rvalid || hit ? RESP : WAIT;
        rdata_d = bus.i_mem_rvalid ? ext : '0;
        trap_d  = !bus.i_mem_rvalid && hit;
        cnt_d   = cnt_q + CW'(1);
      end
      default: begin
        state_d = IDLE;
        trap_d  = 1'b0;
        rdata_d = '0;
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      trap_q   <= 1'b0;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mask_q   <= '0;
      ready_q  <= 1'b1;
      mvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      trap_q   <= trap_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mask_q   <= mask_d;
      ready_q  <= state_d == IDLE;
      mvalid_q <= state_d == REQ;
      rvalid_q <= state_d == RESP;
    end
  end
  assign bus.o_req_ready = ready_q;
  assign bus.o_rsp_valid = rvalid_q;
  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_rsp_trap  = trap_q;
  assign bus.o_mem_valid = mvalid_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wen   = wen_q;
  assign bus.o_mem_ren   = ren_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_mem_mask  = mask_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed self-checking bench for lsu_mem_port (XLEN=32 with TIMEOUT=4, XLEN=64)
module tb_lsu_mem_port;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  int   n;
  logic got;
  always #5 clk = ~clk;
  lsu_mem_port_if #(.XLEN(32)) b32 ();
  lsu_mem_port_if #(.XLEN(64)) b64 ();
  lsu_mem_port #(.XLEN(32), .TIMEOUT(4))   u32 (.i_clk(clk), .i_rst_n(rst_n), .bus(b32));
  lsu_mem_port #(.XLEN(64), .TIMEOUT(255)) u64 (.i_clk(clk), .i_rst_n(rst_n), .bus(b64));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic req32(input logic wen, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    b32.i_req_valid = 1'b1; b32.i_req_wen = wen; b32.i_req_funct3 = f3;
    b32.i_req_addr = addr; b32.i_req_wdata = wd;
  endtask
  task automatic req64(input logic wen, input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wd);
    b64.i_req_valid = 1'b1; b64.i_req_wen = wen; b64.i_req_funct3 = f3;
    b64.i_req_addr = addr; b64.i_req_wdata = wd;
  endtask
  initial begin
    b32.i_req_valid = 0; b32.i_req_wen = 0; b32.i_req_funct3 = 0; b32.i_req_addr = 0;
    b32.i_req_wdata = 0; b32.i_mem_ready = 0; b32.i_mem_rvalid = 0; b32.i_mem_rdata = 0;
    b64.i_req_valid = 0; b64.i_req_wen = 0; b64.i_req_funct3 = 0; b64.i_req_addr = 0;
    b64.i_req_wdata = 0; b64.i_mem_ready = 0; b64.i_mem_rvalid = 0; b64.i_mem_rdata = 0;
    repeat (2) tick();
    chk("rst_ready", b32.o_req_ready, 1);
    chk("rst_mem_valid", b32.o_mem_valid, 0);
    chk("rst_rsp_valid", b32.o_rsp_valid, 0);
    chk("rst_rdata", b32.o_rsp_rdata, 0);
    rst_n = 1'b1;
    tick();
    // load B at 0x1003, memory ready at once, data the cycle after
    b32.i_mem_ready = 1;
    req32(0, 3'b000, 32'h1003, 0);
    tick();
    b32.i_req_valid = 0;
    chk("lb_mem_valid", b32.o_mem_valid, 1);
    chk("lb_mem_addr", b32.o_mem_addr, 32'h1000);
    chk("lb_mask", b32.o_mem_mask, 4'b1000);
    chk("lb_ren", b32.o_mem_ren, 1);
    chk("lb_wen", b32.o_mem_wen, 0);
    chk("lb_ready_busy", b32.o_req_ready, 0);
    tick();
    b32.i_mem_rvalid = 1; b32.i_mem_rdata = 32'h80AABBCC;
    chk("lb_wait_no_rsp", b32.o_rsp_valid, 0);
    tick();
    b32.i_mem_rvalid = 0;
    chk("lb_rsp_valid", b32.o_rsp_valid, 1);
    chk("lb_rdata", b32.o_rsp_rdata, 32'hFFFFFF80);
    chk("lb_trap", b32.o_rsp_trap, 0);
    tick();
    chk("lb_pulse_end", b32.o_rsp_valid, 0);
    chk("lb_rdata_idle", b32.o_rsp_rdata, 0);
    chk("lb_ready_back", b32.o_req_ready, 1);
    // store H at 0x2002, memory ready only on the fourth REQ cycle
    b32.i_mem_ready = 0;
    req32(1, 3'b001, 32'h2002, 32'h1234ABCD);
    tick();
    b32.i_req_valid = 0;
    chk("sh_mask", b32.o_mem_mask, 4'b1100);
    chk("sh_wdata", b32.o_mem_wdata, 32'hABCD0000);
    chk("sh_wen", b32.o_mem_wen, 1);
    chk("sh_ren", b32.o_mem_ren, 0);
    for (int i = 0; i < 4; i++) begin
      chk("sh_valid_held", b32.o_mem_valid, 1);
      if (i == 3) b32.i_mem_ready = 1;
      tick();
    end
    b32.i_mem_ready = 0;
    chk("sh_rsp_valid", b32.o_rsp_valid, 1);
    chk("sh_rsp_trap", b32.o_rsp_trap, 0);
    chk("sh_rsp_rdata", b32.o_rsp_rdata, 0);
    chk("sh_mem_valid_drop", b32.o_mem_valid, 0);
    tick();
    // misaligned load W at 0x0001: trap, no memory request
    req32(0, 3'b010, 32'h0001, 0);
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      b32.i_req_valid = 0;
      chk("lw_mis_no_mem", b32.o_mem_valid, 0);
      got = b32.o_rsp_valid;
    end
    chk("lw_mis_rsp", got, 1);
    chk("lw_mis_trap", b32.o_rsp_trap, 1);
    chk("lw_mis_rdata", b32.o_rsp_rdata, 0);
    tick();
    // store with an unsigned width code is illegal
    req32(1, 3'b100, 32'h0000, 32'hFF);
    tick();
    b32.i_req_valid = 0;
    chk("sbu_no_mem", b32.o_mem_valid, 0);
    chk("sbu_trap", b32.o_rsp_trap, 1);
    tick();
    // load HU at 0x0002 on XLEN=32
    b32.i_mem_ready = 1;
    req32(0, 3'b101, 32'h0002, 0);
    tick();
    b32.i_req_valid = 0;
    chk("lhu_mask", b32.o_mem_mask, 4'b1100);
    tick();
    b32.i_mem_rvalid = 1; b32.i_mem_rdata = 32'h80011234;
    tick();
    b32.i_mem_rvalid = 0;
    chk("lhu_rdata", b32.o_rsp_rdata, 32'h00008001);
    tick();
    // XLEN=64 load WU at 0x0C
    b64.i_mem_ready = 1;
    req64(0, 3'b110, 64'h0C, 0);
    tick();
    b64.i_req_valid = 0;
    chk("lwu64_mask", b64.o_mem_mask, 8'hF0);
    chk("lwu64_addr", b64.o_mem_addr, 64'h08);
    tick();
    b64.i_mem_rvalid = 1; b64.i_mem_rdata = 64'hF000000000000000;
    tick();
    b64.i_mem_rvalid = 0;
    chk("lwu64_rsp", b64.o_rsp_valid, 1);
    chk("lwu64_rdata", b64.o_rsp_rdata, 64'h00000000F0000000);
    tick();
    // XLEN=64 store B at 0x05
    req64(1, 3'b000, 64'h05, 64'h77665544332211AB);
    tick();
    b64.i_req_valid = 0;
    chk("sb64_mask", b64.o_mem_mask, 8'h20);
    chk("sb64_wdata", b64.o_mem_wdata, 64'h0000AB0000000000);
    tick();
    chk("sb64_rsp", b64.o_rsp_valid, 1);
    b64.i_mem_ready = 0;
    tick();
    // timeout: memory accepts, read data never comes
    req32(0, 3'b010, 32'h0010, 0);
    tick();
    b32.i_req_valid = 0;
    tick();
    b32.i_mem_ready = 0;
    n = 0;
    for (int i = 0; i < 10 && !b32.o_rsp_valid; i++) begin
      n++;
      tick();
    end
    chk("to_wait_cycles", n, 4);
    chk("to_rsp", b32.o_rsp_valid, 1);
    chk("to_trap", b32.o_rsp_trap, 1);
    chk("to_rdata", b32.o_rsp_rdata, 0);
    tick();
    b32.i_mem_rvalid = 1; b32.i_mem_rdata = 32'hDEADBEEF;
    tick();
    b32.i_mem_rvalid = 0;
    chk("late_rvalid_ignored", b32.o_rsp_valid, 0);
    chk("late_ready", b32.o_req_ready, 1);
    // reset in the middle of REQ
    req32(0, 3'b000, 32'h1001, 0);
    tick();
    b32.i_req_valid = 0;
    chk("mid_req_valid", b32.o_mem_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_valid", b32.o_mem_valid, 0);
    chk("rst_mid_ready", b32.o_req_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    b32.i_mem_ready = 1;
    req32(0, 3'b100, 32'h1001, 0);
    tick();
    b32.i_req_valid = 0;
    chk("post_rst_mask", b32.o_mem_mask, 4'b0010);
    tick();
    b32.i_mem_rvalid = 1; b32.i_mem_rdata = 32'h80AABBCC;
    tick();
    b32.i_mem_rvalid = 0;
    chk("post_rst_rsp", b32.o_rsp_valid, 1);
    chk("post_rst_rdata", b32.o_rsp_rdata, 32'h000000BB);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
